credit_rr_arbiter: RTL and testbench

- Round-robin pop scheduler for NUM_REQS parallel fifos that share one downstream sink.
- Picks at most one non-empty fifo per cycle and drives its pop.
- Grants are gated by a downstream credit counter, so the sink (depth CREDITS) can never overflow.
- Sits between the fifo array and the sink in the Scoreboard-style harness; its gnt drives fifo pop directly.

---
 rtl/credit_rr_arbiter_pkg.sv | 9 +
 rtl/credit_rr_arbiter_rr_pick.sv | 51 +++++
 rtl/credit_rr_arbiter.sv | 73 +++++++
 tb/tb_credit_rr_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/credit_rr_arbiter_pkg.sv
// Shared defaults for the credit-gated round-robin pop scheduler.
package credit_rr_arbiter_pkg;

  // Default number of parallel fifos feeding the shared sink.
  localparam int NUM_REQS_DEF   = 4;
  // Default sink depth, which is also the initial and maximum credit count.
  localparam int FIFO_DEPTH_DEF = 8;

endpackage : credit_rr_arbiter_pkg

// File: rtl/credit_rr_arbiter_rr_pick.sv
// Round-robin picker: starting one past ptr, select the first active request.
// Uses a double-width copy of reqs so the wrap-around search is a single
// rotate followed by a lowest-bit priority select.
module credit_rr_arbiter_rr_pick #(
  parameter int NUM_REQS = 4,
  parameter int PWID     = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] reqs,
  input  logic [PWID-1:0]     ptr,
  input  logic                en,
  output logic [NUM_REQS-1:0] gnt,
  output logic [PWID-1:0]     idx
);

  logic [2*NUM_REQS-1:0] dbl;
  logic [NUM_REQS-1:0]   rot;
  logic [PWID-1:0]       start;
  logic [PWID-1:0]       off;
  logic [PWID:0]         sum;
  logic                  found;

  assign dbl = {reqs, reqs};

  // Rotate so the search origin sits at bit 0, pick lowest set bit, map back.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    start = (ptr == PWID'(NUM_REQS - 1)) ? '0 : ptr + 1'b1;
    rot   = dbl[start +: NUM_REQS];
    off   = '0;
    found = 1'b0;
    gnt   = '0;
    // Descending scan: the last hit written is the lowest index, i.e. the
    // nearest requester after ptr.
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = PWID'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (PWID + 1)'(NUM_REQS)) begin
      sum = sum - (PWID + 1)'(NUM_REQS);
    end
    idx = sum[PWID-1:0];
    if (en && found) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule : credit_rr_arbiter_rr_pick

// File: rtl/credit_rr_arbiter.sv
// Credit-gated round-robin pop scheduler for NUM_REQS fifos sharing one sink.
// gnt is combinational and drives fifo pop directly; the credit counter keeps
// the sink (depth CREDITS) from ever overflowing.
module credit_rr_arbiter
  import credit_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQS = NUM_REQS_DEF,
  parameter int CREDITS  = FIFO_DEPTH_DEF,
  parameter int CWID     = $clog2(CREDITS) + 1,
  parameter int PWID     = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                blk,
  input  logic [NUM_REQS-1:0] reqs,
  input  logic                credit_ret,
  output logic [NUM_REQS-1:0] gnt,
  output logic                gnt_vld,
  output logic [CWID-1:0]     credits,
  output logic                err
);

  localparam logic [CWID-1:0] CRED_MAX = CWID'(CREDITS);
  localparam logic [PWID-1:0] PTR_RST  = PWID'(NUM_REQS - 1);

  logic [PWID-1:0] ptr;
  logic [PWID-1:0] pick_idx;
  logic            can_gnt;

  // A grant needs: not in reset, not blocked, a free sink slot, a non-empty fifo.
  assign can_gnt = ~rst & ~blk & (credits != '0) & (|reqs);

  credit_rr_arbiter_rr_pick #(
    .NUM_REQS (NUM_REQS),
    .PWID     (PWID)
  ) u_pick (
    .reqs (reqs),
    .ptr  (ptr),
    .en   (can_gnt),
    .gnt  (gnt),
    .idx  (pick_idx)
  );

  assign gnt_vld = |gnt;

  // Pointer, credit counter and sticky overflow error, all reset synchronously.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ptr     <= PTR_RST;
      credits <= CRED_MAX;
      err     <= 1'b0;
    end else begin
      if (gnt_vld) begin
        ptr <= pick_idx;
      end
      // A simultaneous grant and return cancel out, even at full credits.
      unique case ({gnt_vld, credit_ret})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CRED_MAX) begin
            err <= 1'b1;
          end else begin
            credits <= credits + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : credit_rr_arbiter

// File: tb/tb_credit_rr_arbiter.sv
// Self-checking bench for credit_rr_arbiter: a behavioural model predicts each
// cycle's outputs into a queue as stimulus is driven; the queue is popped and
// compared against the DUT on the falling edge.
module tb_credit_rr_arbiter;

  localparam int N    = 4;
  localparam int CRED = 8;
  localparam int CW   = 4;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          vld;
    logic [CW-1:0] credits;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk;
  logic [N-1:0]  reqs;
  logic          credit_ret;
  logic [N-1:0]  gnt;
  logic          gnt_vld;
  logic [CW-1:0] credits;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];

  // Model state
  int m_ptr;
  int m_credits;
  bit m_err;

  always #5 clk = ~clk;

  credit_rr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .blk        (blk),
    .reqs       (reqs),
    .credit_ret (credit_ret),
    .gnt        (gnt),
    .gnt_vld    (gnt_vld),
    .credits    (credits),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr     = N - 1;
    m_credits = CRED;
    m_err     = 1'b0;
  endtask

  // One cycle: drive inputs, predict, compare at negedge, advance model at posedge.
  task automatic step(input bit r, input bit b, input logic [N-1:0] rq, input bit ret,
                      input string tag);
    exp_t e;
    int   gi;
    exp_t o;
    rst = r; blk = b; reqs = rq; credit_ret = ret;
    gi = -1;
    if (!r && !b && m_credits != 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (gi < 0 && rq[i]) gi = i;
      end
    end
    e.gnt     = (gi >= 0) ? N'(1 << gi) : '0;
    e.vld     = (gi >= 0);
    e.credits = CW'(m_credits);
    e.err     = m_err;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, ":queue"}, 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      check({tag, ":gnt"},     32'(gnt),     32'(o.gnt));
      check({tag, ":gnt_vld"}, 32'(gnt_vld), 32'(o.vld));
      check({tag, ":credits"}, 32'(credits), 32'(o.credits));
      check({tag, ":err"},     32'(err),     32'(o.err));
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (gi >= 0) m_ptr = gi;
      if (gi >= 0 && !ret)      m_credits--;
      else if (gi < 0 && ret) begin
        if (m_credits == CRED) m_err = 1'b1;
        else                   m_credits++;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; blk = 1'b0; reqs = '0; credit_ret = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state held
    step(1, 0, 4'b1111, 0, "rst_hold");
    step(1, 0, 4'b0000, 1, "rst_hold2");

    // All requesters, no credit return: eight rotating grants then starvation
    for (int c = 0; c < 10; c++) step(0, 0, 4'b1111, 0, "rr_all");
    check("drained_credits", 32'(credits), 32'd0);

    // Zero credits: return pulse enables a grant next cycle only
    step(0, 0, 4'b0010, 1, "zero_ret");
    step(0, 0, 4'b0010, 0, "zero_after");
    step(0, 0, 4'b0010, 0, "zero_again");

    // Alternating pair with a return on every grant cycle
    step(1, 0, 4'b0000, 0, "rst2");
    for (int c = 0; c < 8; c++) step(0, 0, 4'b0101, 1, "pair_ret");
    check("pair_credits_full", 32'(credits), 32'd8);

    // Idle return at full credits sets sticky err
    step(0, 0, 4'b0000, 1, "over_ret");
    for (int c = 0; c < 3; c++) step(0, 0, 4'b0000, 0, "err_sticky");
    check("err_sticky_direct", 32'(err), 32'd1);

    // Blocked mid-stream after granting req1, then resume at req2
    step(1, 0, 4'b0000, 0, "rst3");
    step(0, 0, 4'b1111, 0, "blk_pre0");
    step(0, 0, 4'b1111, 0, "blk_pre1");
    for (int c = 0; c < 3; c++) step(0, 1, 4'b1111, 0, "blk_on");
    step(0, 0, 4'b1111, 0, "blk_resume");
    check("blk_resume_direct", 32'(ptr_probe()), 32'd2);

    // Reset mid-operation: grant drops at once, restart from req0
    step(1, 0, 4'b1111, 0, "rst_mid");
    step(0, 0, 4'b1111, 0, "rst_first");

    // Single requester granted every cycle while credits last
    step(1, 0, 4'b0000, 0, "rst4");
    for (int c = 0; c < 10; c++) step(0, 0, 4'b1000, 0, "single");

    // Random traffic
    step(1, 0, 4'b0000, 0, "rst5");
    for (int c = 0; c < 60; c++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0),
           N'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), "rand");
    end

    if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Model pointer value, as seen by the bench after the last step.
  function automatic int ptr_probe();
    return m_ptr;
  endfunction

endmodule : tb_credit_rr_arbiter
